// File: rtl/dr_alm_post_antilog.sv
// rtl/dr_alm_post_antilog.sv - DR-ALM antilog back end: {k,frac} -> (1.frac)*2^k, two-stage valid/ready pipe
// Optional macro DR_ALM_ROUND_EN: round half-up on right shifts (k < FW) instead of floor.
module dr_alm_post_antilog #(
  parameter int A_BW    = 32,
  parameter int B_BW    = 32,
  parameter int MULT_DW = 5,
  parameter int TRUNC_W = MULT_DW + 1,
  parameter int BW_LG   = $clog2((A_BW > B_BW) ? A_BW : B_BW),
  parameter int OW      = A_BW + B_BW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BW_LG+TRUNC_W+1:0]   in_l,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OW-1:0]              out_ap,
  output logic                       out_ovf
);

  localparam int FW   = TRUNC_W + 1;
  localparam int KW   = BW_LG + 1;
  localparam int KMAX = (A_BW - 1) + (B_BW - 1);

  logic              s1_valid_q, s1_valid_d;
  logic [FW:0]       s1_mant_q, s1_mant_d;
  logic [KW-1:0]     s1_k_q, s1_k_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_ovf_q, s1_ovf_d;
  logic              s2_valid_q, s2_valid_d;
  logic [OW-1:0]     out_ap_q, out_ap_d;
  logic              out_ovf_q, out_ovf_d;

  logic              s1_adv, s2_adv;
  logic [KW-1:0]     in_k;
  logic [OW-1:0]     mant_ext, shifted;
  logic [KW-1:0]     shamt;
`ifdef DR_ALM_ROUND_EN
  logic [OW-1:0]     rounded;
`endif

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_ap    = out_ap_q;
  assign out_ovf   = out_ovf_q;
  assign in_k      = in_l[KW+FW-1:FW];

  // Stage 1: capture the mantissa with its hidden one and classify k.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_k_d     = s1_k_q;
    s1_zero_d  = s1_zero_q;
    s1_ovf_d   = s1_ovf_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mant_d = {1'b1, in_l[FW-1:0]};
        s1_k_d    = in_k;
        s1_zero_d = in_zero;
        s1_ovf_d  = (int'(in_k) > KMAX);
      end
    end
  end

  // Stage 2: barrel shift relative to the binary point at bit FW.
  always_comb begin
    mant_ext = OW'(s1_mant_q);
    shamt    = '0;
    shifted  = '0;
`ifdef DR_ALM_ROUND_EN
    rounded  = mant_ext;
`endif
    if (s1_k_q >= KW'(FW)) begin
      shamt   = s1_k_q - KW'(FW);
      shifted = mant_ext << shamt;
    end else begin
      shamt   = KW'(FW) - s1_k_q;
`ifdef DR_ALM_ROUND_EN
      rounded = mant_ext + (OW'(1) << (shamt - KW'(1)));
      shifted = rounded >> shamt;
`else
      shifted = mant_ext >> shamt;
`endif
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_ap_d   = out_ap_q;
    out_ovf_d  = out_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_zero_q) begin
          out_ap_d  = '0;
          out_ovf_d = 1'b0;
        end else if (s1_ovf_q) begin
          out_ap_d  = '1;
          out_ovf_d = 1'b1;
        end else begin
          out_ap_d  = shifted;
          out_ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_k_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_ap_q   <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_k_q     <= s1_k_d;
      s1_zero_q  <= s1_zero_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s2_valid_d;
      out_ap_q   <= out_ap_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule
